// File: rtl/aes_dec_ctrl.sv
// Iterative AES-128 decryption sequencer: steps a 128-bit state register through
// NR+1 inverse-round operations on an external datapath, with valid/ready on both sides.
module aes_dec_ctrl #(
    parameter int unsigned NR    = 10,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    input  logic             key_valid,
    output logic [3:0]       key_idx,
    output logic [1:0]       rnd_mode,
    output logic [127:0]     rnd_in,
    input  logic [127:0]     rnd_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             busy,
    output logic             abort,
    output logic [CNT_W-1:0] blk_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {PRE = 2'd0, MID = 2'd1, LAST = 2'd2} mode_t;

    localparam logic [3:0] LAST_STEP = 4'(NR);

    state_t             state;
    state_t             state_nxt;
    logic [127:0]       st;
    logic [3:0]         step;
    logic [CNT_W-1:0]   cnt;
    logic               abort_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid && key_valid) state_nxt = RUN;
            RUN: begin
                // Losing the keys mid-block drops the block rather than stalling
                if (!key_valid)              state_nxt = IDLE;
                else if (step == LAST_STEP)  state_nxt = DONE;
            end
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= '0;
            step    <= '0;
            cnt     <= '0;
            abort_q <= 1'b0;
        end else begin
            abort_q <= (state == RUN) && !key_valid;
            case (state)
                IDLE: begin
                    if (in_valid && key_valid) begin
                        st   <= in_data;
                        step <= '0;
                    end
                end
                RUN: begin
                    if (key_valid) begin
                        st   <= rnd_out;
                        step <= step + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) cnt <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        key_idx   = LAST_STEP;
        rnd_mode  = PRE;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: in_ready = key_valid;
            RUN: begin
                busy    = 1'b1;
                key_idx = LAST_STEP - step;
                if (step == '0)             rnd_mode = PRE;
                else if (step == LAST_STEP) rnd_mode = LAST;
                else                        rnd_mode = MID;
            end
            DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    assign rnd_in   = st;
    assign out_data = st;
    assign abort    = abort_q;
    assign blk_cnt  = cnt;

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Bench for aes_dec_ctrl: supplies a behavioural inverse-round datapath and key table,
// and checks every cycle against a block-level timing model plus full AES decryption.
module tb_aes_dec_ctrl;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk, rst;
    logic         in_valid, key_valid, out_ready;
    logic [127:0] in_data;

    logic         in_ready, out_valid, busy, abort;
    logic [3:0]   key_idx;
    logic [1:0]   rnd_mode;
    logic [127:0] rnd_in, rnd_out, out_data;
    logic [15:0]  blk_cnt;

    logic         in_ready2, out_valid2, busy2, abort2;
    logic [3:0]   key_idx2;
    logic [1:0]   rnd_mode2;
    logic [127:0] rnd_in2, rnd_out2, out_data2;
    logic [1:0]   blk_cnt2;

    logic [7:0]   sbox [256];
    logic [7:0]   isbox[256];
    logic [127:0] rk   [11];

    int n_vec = 0;
    int n_err = 0;

    aes_dec_ctrl #(.NR(10), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .key_valid(key_valid), .key_idx(key_idx), .rnd_mode(rnd_mode), .rnd_in(rnd_in),
        .rnd_out(rnd_out), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .abort(abort), .blk_cnt(blk_cnt)
    );

    aes_dec_ctrl #(.NR(10), .CNT_W(2)) u_dut_w2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .key_valid(key_valid), .key_idx(key_idx2), .rnd_mode(rnd_mode2), .rnd_in(rnd_in2),
        .rnd_out(rnd_out2), .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .busy(busy2), .abort(abort2), .blk_cnt(blk_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] d = {v, v};
        return d[15-n -: 8];
    endfunction

    // One inverse-round step as the external datapath would compute it
    function automatic logic [127:0] rnd_fn(input logic [127:0] s, input logic [3:0] k,
                                            input logic [1:0] m);
        logic [7:0]   b[16];
        logic [7:0]   t[16];
        logic [127:0] key;
        logic [127:0] r;
        key = (k <= 4'd10) ? rk[k] : '0;
        if (m == 2'd0) return s ^ key;
        for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
                t[rw + 4*c] = isbox[b[rw + 4*((c - rw + 4) % 4)]];
        for (int i = 0; i < 16; i++) t[i] = t[i] ^ key[127-8*i -: 8];
        if (m == 2'd1) begin
            for (int c = 0; c < 4; c++) begin
                b[4*c]   = gmul(t[4*c],8'h0e) ^ gmul(t[4*c+1],8'h0b) ^ gmul(t[4*c+2],8'h0d) ^ gmul(t[4*c+3],8'h09);
                b[4*c+1] = gmul(t[4*c],8'h09) ^ gmul(t[4*c+1],8'h0e) ^ gmul(t[4*c+2],8'h0b) ^ gmul(t[4*c+3],8'h0d);
                b[4*c+2] = gmul(t[4*c],8'h0d) ^ gmul(t[4*c+1],8'h09) ^ gmul(t[4*c+2],8'h0e) ^ gmul(t[4*c+3],8'h0b);
                b[4*c+3] = gmul(t[4*c],8'h0b) ^ gmul(t[4*c+1],8'h0d) ^ gmul(t[4*c+2],8'h09) ^ gmul(t[4*c+3],8'h0e);
            end
            for (int i = 0; i < 16; i++) t[i] = b[i];
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
        return r;
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] ct);
        logic [127:0] s = rnd_fn(ct, 4'd10, 2'd0);
        for (int r = 9; r >= 1; r--) s = rnd_fn(s, 4'(r), 2'd1);
        return rnd_fn(s, 4'd0, 2'd2);
    endfunction

    always_comb rnd_out  = rnd_fn(rnd_in, key_idx, rnd_mode);
    always_comb rnd_out2 = rnd_fn(rnd_in2, key_idx2, rnd_mode2);

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: m_age = cycles since the accepting edge (0 = idle), m_cnt = completed handshakes
    int           m_age = 0;
    int           m_cnt = 0;
    bit           m_abort = 0;
    logic [127:0] m_ct = '0;
    logic [127:0] m_pt = '0;

    initial begin
        logic [31:0] w[44];
        logic [31:0] tw;
        logic [7:0]  rc;
        logic [7:0]  inv;
        logic [7:0]  sv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sv = inv ^ rotl(inv,1) ^ rotl(inv,2) ^ rotl(inv,3) ^ rotl(inv,4) ^ 8'h63;
            sbox[x]  = sv;
            isbox[sv] = 8'(x);
        end
        for (int i = 0; i < 4; i++) w[i] = FIPS_KEY[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tw = w[i-1];
            if (i % 4 == 0) begin
                tw = {tw[23:0], tw[31:24]};
                tw = {sbox[tw[31:24]], sbox[tw[23:16]], sbox[tw[15:8]], sbox[tw[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tw;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

        chk("model_rk10", rk[10], FIPS_RK10);
        chk("model_fips", aes_dec(FIPS_CT), FIPS_PT);

        forever begin
            @(negedge clk);
            if (rst) begin
                m_age = 0; m_cnt = 0; m_abort = 0;
                chk("rst_busy",      128'(busy),      '0);
                chk("rst_out_valid", 128'(out_valid), '0);
                chk("rst_out_data",  out_data,        '0);
                chk("rst_rnd_in",    rnd_in,          '0);
                chk("rst_key_idx",   128'(key_idx),   128'(10));
                chk("rst_rnd_mode",  128'(rnd_mode),  '0);
                chk("rst_abort",     128'(abort),     '0);
                chk("rst_blk_cnt",   128'(blk_cnt),   '0);
                chk("rst_in_ready",  128'(in_ready),  128'(key_valid));
                chk("rst_blk_cnt2",  128'(blk_cnt2),  '0);
                chk("rst_busy2",     128'(busy2),     '0);
            end else begin
                bit run, done;
                run  = (m_age >= 1) && (m_age <= 11);
                done = (m_age >= 12);
                chk("busy",      128'(busy),      128'(run));
                chk("out_valid", 128'(out_valid), 128'(done));
                chk("in_ready",  128'(in_ready),  128'((m_age == 0) && key_valid));
                chk("abort",     128'(abort),     128'(m_abort));
                chk("blk_cnt",   128'(blk_cnt),   128'(m_cnt % 65536));
                chk("key_idx",   128'(key_idx),   run ? 128'(11 - m_age) : 128'(10));
                chk("rnd_mode",  128'(rnd_mode),
                    !run ? 128'(0) : (m_age == 1) ? 128'(0) : (m_age == 11) ? 128'(2) : 128'(1));
                chk("w2_blk_cnt",   128'(blk_cnt2),   128'(m_cnt % 4));
                chk("w2_out_valid", 128'(out_valid2), 128'(done));
                chk("w2_busy",      128'(busy2),      128'(run));
                chk("w2_abort",     128'(abort2),     128'(m_abort));
                chk("w2_in_ready",  128'(in_ready2),  128'((m_age == 0) && key_valid));
                if (m_age == 1) chk("rnd_in_first", rnd_in, m_ct);
                if (done) begin
                    chk("out_data",    out_data,  m_pt);
                    chk("rnd_in_done", rnd_in,    m_pt);
                    chk("w2_out_data", out_data2, m_pt);
                    if (m_ct == FIPS_CT) chk("fips_plaintext", out_data, FIPS_PT);
                end

                m_abort = 0;
                if (m_age == 0) begin
                    if (in_valid && key_valid) begin
                        m_age = 1; m_ct = in_data; m_pt = aes_dec(in_data);
                    end
                end else if (run) begin
                    if (!key_valid) begin
                        m_age = 0; m_abort = 1;
                    end else begin
                        m_age++;
                    end
                end else if (out_ready) begin
                    m_cnt++; m_age = 0;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic send(input logic [127:0] ct, input bit hold);
        in_valid = 1'b1;
        in_data  = ct;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (in_ready) begin
                cyc();
                if (!hold) in_valid = 1'b0;
                return;
            end
            cyc();
        end
        $display("FAIL send_timeout: in_ready never rose for %h", ct);
        $fatal(1, "acceptance timeout");
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; key_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        key_valid = 1'b1; out_ready = 1'b1;

        send(FIPS_CT, 1'b0);
        idle(14);

        out_ready = 1'b0;
        send(FIPS_CT, 1'b0);
        idle(31);
        out_ready = 1'b1;
        idle(3);

        send(128'h0123456789abcdeffedcba9876543210, 1'b1);
        send(128'hdeadbeef00000000cafef00d11111111, 1'b1);
        send(128'hffffffffffffffffffffffffffffffff, 1'b0);
        idle(14);

        key_valid = 1'b0; in_valid = 1'b1; in_data = FIPS_CT;
        idle(5);
        key_valid = 1'b1;
        send(FIPS_CT, 1'b0);
        idle(4);
        key_valid = 1'b0;
        idle(1);
        key_valid = 1'b1;
        idle(20);

        send(FIPS_CT, 1'b0);
        idle(6);
        #2 rst = 1'b1;
        #5 rst = 1'b0;
        @(posedge clk); #1;
        send(128'h00000000000000000000000000000000, 1'b0);
        idle(14);

        for (int i = 0; i < 900; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom % 3) != 0;
            key_valid = ($urandom % 60) != 0;
            cyc();
        end
        in_valid = 1'b0; key_valid = 1'b1; out_ready = 1'b1;
        idle(15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_dec_ctrl.md
# aes_dec_ctrl

Iterative sequencer for the AES-128 decryption datapath. It accepts one ciphertext block over a valid/ready handshake and holds it in an internal 128-bit state register. Each cycle it drives that register, a round-key index and a round mode into the external combinational inverse-round datapath, capturing the result, for 11 steps. It then presents the plaintext over a second valid/ready handshake. It sits between the host interface and the shared inverse-round logic and key-expansion table.

## Interface
Parameters:
- NR, 10, number of AES rounds; fixes the key-index range 0..NR.
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  ciphertext offered.
- in_ready  out  1  controller can accept ciphertext.
- in_data  in  128  ciphertext block.
- key_valid  in  1  expanded round keys are stable.
- key_idx  out  4  round-key select to the key table: 10 selects key 10 (last expanded key), 0 selects the cipher key.
- rnd_mode  out  2  datapath step select: 0 = PRE (AddRoundKey only), 1 = MID (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns), 2 = LAST (same as MID without InvMixColumns).
- rnd_in  out  128  state register contents, fed to the datapath.
- rnd_out  in  128  datapath result for the current rnd_in, key_idx and rnd_mode.
- out_valid  out  1  plaintext available.
- out_ready  in  1  consumer accepts plaintext.
- out_data  out  128  plaintext block.
- busy  out  1  block in flight (RUN).
- abort  out  1  one-cycle pulse when a block is dropped.
- blk_cnt  out  CNT_W  number of completed output handshakes; wraps.

## Operation
- States: IDLE, RUN, DONE. A 4-bit step counter `step` runs 0..NR.
- IDLE:
  - in_ready = key_valid (combinational); key_idx = NR; rnd_mode = PRE.
  - When in_valid & in_ready: st <= in_data, step <= 0, go to RUN.
- RUN, each cycle:
  - key_idx = NR - step.
  - rnd_mode = PRE if step == 0; LAST if step == NR; MID otherwise.
  - st <= rnd_out and step increments.
  - The step == NR cycle moves to DONE.
- DONE:
  - out_valid = 1 and out_data = st.
  - st holds until out_valid & out_ready; then blk_cnt increments (wrapping at 2^CNT_W) and the FSM goes to IDLE.
- rnd_in = st in all states. Outputs out_data, rnd_in and key_idx are driven from registers or from state decode only; no combinational path from rnd_out to any output.
- Abort: if key_valid is low in any RUN cycle, st is not updated. The FSM goes to IDLE, abort pulses for 1 cycle, and blk_cnt is unchanged.
- In DONE, key_valid is ignored; the finished result stays valid.
- in_ready is 0 in RUN and DONE. No overlap between blocks.

## Timing
- Reset values: state IDLE, st 0, step 0, key_idx NR, rnd_mode 0, out_valid 0, out_data 0, busy 0, abort 0, blk_cnt 0. in_ready follows key_valid immediately after reset.
- Acceptance edge is T0. RUN covers cycles T0+1 .. T0+11. out_valid rises after edge T0+11, so it is first high in cycle T0+12: 11 cycles of processing.
- If out_ready is held high, out_valid is high for exactly 1 cycle and in_ready returns in cycle T0+13. Minimum block period is 13 cycles.
- Output backpressure: out_data stays stable while out_valid & !out_ready, for any number of cycles.
- Reset asserted mid-RUN or in DONE: all registers return to reset values asynchronously and the in-flight block is lost. No abort pulse.
- An in_valid/out_ready event in the same cycle as rst is ignored.

## Test plan
- FIPS-197 vector. Key 000102030405060708090a0b0c0d0e0f. in_data 69c4e0d86a7b0430d8cdb78070b4c55a accepted at T0 with out_ready = 1.
  - Required: out_valid first high at T0+12 with out_data 00112233445566778899aabbccddeeff.
  - key_idx sequence during RUN is 10,9,..,0; rnd_mode sequence is 0,1×9,2; blk_cnt = 1.
- Backpressure: same block with out_ready held low for 20 cycles. out_valid and out_data stay stable throughout; in_ready stays 0; release gives exactly one handshake.
- Back-to-back: in_valid held high with 3 ciphertexts and out_ready = 1. Accept edges are 13 cycles apart; results arrive in order; blk_cnt = 3.
- key_valid gating and abort:
  - key_valid = 0 in IDLE: in_ready = 0 and the block is not accepted.
  - Drop key_valid for 1 cycle at T0+5: abort pulses once, the FSM is back in IDLE, out_valid never rises, blk_cnt unchanged.
- Async reset: assert rst at T0+7 for a half cycle. busy and out_valid go to 0 immediately and all outputs hold reset values. The next block then decrypts correctly.
- Counter wrap: with CNT_W = 2, complete 5 blocks. blk_cnt reads 1,2,3,0,1.
